// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode and MEM/WB operand forwarding
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [2:0]        id_funct,
    input  logic              id_alu_src,
    input  logic [3:0]        id_ctrl,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic [2:0]        ALUControl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic [3:0]        ex_ctrl,
    output logic              ex_valid,
    output logic              ex_illegal,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);
    logic              valid_q, valid_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [2:0]        aluc_q, aluc_d;
    logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic              illegal_q, illegal_d;
    logic              alu_src_q, alu_src_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [DATA_W-1:0] op_a, op_b;
    logic              legal;
    logic [2:0]        dec_aluc;

    // MEM beats WB; r0 and bubbles never forward
    always_comb begin
        fwd_a = !valid_q || rs_q == '0 ? 2'b00 :
                mem_reg_write && mem_rd == rs_q ? 2'b10 :
                wb_reg_write && wb_rd == rs_q ? 2'b01 : 2'b00;
        fwd_b = !valid_q || rt_q == '0 ? 2'b00 :
                mem_reg_write && mem_rd == rt_q ? 2'b10 :
                wb_reg_write && wb_rd == rt_q ? 2'b01 : 2'b00;
        op_a = fwd_a == 2'b10 ? mem_result : fwd_a == 2'b01 ? wb_result : rs_data_q;
        op_b = fwd_b == 2'b10 ? mem_result : fwd_b == 2'b01 ? wb_result : rt_data_q;
        input1 = op_a;
        input2 = alu_src_q ? imm_q : op_b;
        ex_store_data = op_b;
    end

    // ALU opcode decode of the incoming ID instruction; R-type funct 101-111 is unsupported
    always_comb begin
        legal = id_alu_op != 2'b10 || id_funct <= 3'd4;
        dec_aluc = id_alu_op == 2'b00 ? 3'b010 :
                   id_alu_op == 2'b01 ? 3'b011 :
                   id_alu_op == 2'b11 ? 3'b001 :
                   legal ? id_funct : 3'b000;
    end

    // next EX state: flush or empty ID loads a bubble, stall holds but refreshes operand data
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        aluc_d    = aluc_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        illegal_d = illegal_q;
        alu_src_d = alu_src_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        if (flush || (!stall && !id_valid)) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            aluc_d    = '0;
            rd_d      = '0;
            rs_d      = '0;
            rt_d      = '0;
            illegal_d = 1'b0;
            alu_src_d = 1'b0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
        end else if (stall) begin
            rs_data_d = op_a;
            rt_data_d = op_b;
        end else begin
            valid_d   = 1'b1;
            ctrl_d    = legal ? id_ctrl : 4'b0000;
            aluc_d    = dec_aluc;
            rd_d      = id_rd;
            rs_d      = id_rs;
            rt_d      = id_rt;
            illegal_d = !legal;
            alu_src_d = id_alu_src;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
        end
    end

    // EX register bank, cleared immediately on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            aluc_q    <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            illegal_q <= 1'b0;
            alu_src_q <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            aluc_q    <= aluc_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            illegal_q <= illegal_d;
            alu_src_q <= alu_src_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
        end
    end

    assign ALUControl = aluc_q;
    assign ex_rd      = rd_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_valid   = valid_q;
    assign ex_illegal = illegal_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, corner sequences and random run against a reference model
module tb_id_ex_stage;
    logic        clock, reset, stall, flush, id_valid;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct;
    logic        id_alu_src;
    logic [3:0]  id_ctrl;
    logic        mem_reg_write, wb_reg_write;
    logic [2:0]  mem_rd, wb_rd;
    logic [15:0] mem_result, wb_result;
    logic [15:0] input1, input2, ex_store_data;
    logic [2:0]  ALUControl, ex_rd;
    logic [3:0]  ex_ctrl;
    logic        ex_valid, ex_illegal;
    logic [1:0]  fwd_a, fwd_b;
    int checks, errors;

    id_ex_stage #(.DATA_W(16), .REG_AW(3)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_funct(id_funct), .id_alu_src(id_alu_src), .id_ctrl(id_ctrl),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_result(mem_result), .wb_result(wb_result),
        .input1(input1), .input2(input2), .ALUControl(ALUControl),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_valid(ex_valid), .ex_illegal(ex_illegal), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // model of the instruction currently sitting in EX
    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [2:0]  alu;
        logic [2:0]  rd, rs, rt;
        logic        ill, src;
        logic [15:0] a, b, imm;
    } ex_t;
    ex_t m;
    logic [2:0] optab [4];

    typedef struct {
        logic [1:0] op; logic [2:0] funct; logic src; logic [3:0] ctrl;
        logic [2:0] rs, rt, rd; logic [15:0] rsd, rtd, imm; logic v;
        logic mw; logic [2:0] mrd; logic [15:0] mres;
        logic ww; logic [2:0] wrd; logic [15:0] wres;
        logic ev; logic [2:0] ealu; logic [3:0] ectrl; logic eill; logic [2:0] erd;
        logic [15:0] e1, e2, es; logic [1:0] efa, efb;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t mk(int op, int funct, int src, int ctrl, int rs, int rt, int rd,
                                int rsd, int rtd, int imm, int v, int mw, int mrd, int mres,
                                int ww, int wrd, int wres, int ev, int ealu, int ectrl, int eill,
                                int erd, int e1, int e2, int es, int efa, int efb);
        vec_t t;
        t.op = 2'(op); t.funct = 3'(funct); t.src = 1'(src); t.ctrl = 4'(ctrl);
        t.rs = 3'(rs); t.rt = 3'(rt); t.rd = 3'(rd);
        t.rsd = 16'(rsd); t.rtd = 16'(rtd); t.imm = 16'(imm); t.v = 1'(v);
        t.mw = 1'(mw); t.mrd = 3'(mrd); t.mres = 16'(mres);
        t.ww = 1'(ww); t.wrd = 3'(wrd); t.wres = 16'(wres);
        t.ev = 1'(ev); t.ealu = 3'(ealu); t.ectrl = 4'(ectrl); t.eill = 1'(eill); t.erd = 3'(erd);
        t.e1 = 16'(e1); t.e2 = 16'(e2); t.es = 16'(es); t.efa = 2'(efa); t.efb = 2'(efb);
        return t;
    endfunction

    function automatic logic [1:0] fsel(input logic [2:0] src);
        if (!m.valid || src == 3'd0) return 2'd0;
        if (mem_reg_write && mem_rd == src) return 2'd2;
        if (wb_reg_write && wb_rd == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [15:0] fval(input logic [1:0] s, input logic [15:0] st);
        return s == 2'd2 ? mem_result : s == 2'd1 ? wb_result : st;
    endfunction

    task automatic model_edge();
        logic ok;
        if (flush || (!stall && !id_valid)) m = '0;
        else if (stall) begin
            m.a = fval(fsel(m.rs), m.a);
            m.b = fval(fsel(m.rt), m.b);
        end else begin
            ok = !(id_alu_op == 2'd2 && id_funct > 3'd4);
            m.valid = 1'b1;
            m.alu = id_alu_op == 2'd2 ? (ok ? id_funct : 3'd0) : optab[id_alu_op];
            m.ctrl = ok ? id_ctrl : 4'd0;
            m.ill = !ok;
            m.rd = id_rd; m.rs = id_rs; m.rt = id_rt; m.src = id_alu_src;
            m.a = id_rs_data; m.b = id_rt_data; m.imm = id_imm;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) m = '0;
        else model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [2:0] ealu,
                             input logic [3:0] ectrl, input logic eill, input logic [2:0] erd,
                             input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] es,
                             input logic [1:0] efa, input logic [1:0] efb);
        chk({tag, ".ex_valid"}, 16'(ex_valid), 16'(ev));
        chk({tag, ".ALUControl"}, 16'(ALUControl), 16'(ealu));
        chk({tag, ".ex_ctrl"}, 16'(ex_ctrl), 16'(ectrl));
        chk({tag, ".ex_illegal"}, 16'(ex_illegal), 16'(eill));
        chk({tag, ".ex_rd"}, 16'(ex_rd), 16'(erd));
        chk({tag, ".input1"}, input1, e1);
        chk({tag, ".input2"}, input2, e2);
        chk({tag, ".ex_store_data"}, ex_store_data, es);
        chk({tag, ".fwd_a"}, 16'(fwd_a), 16'(efa));
        chk({tag, ".fwd_b"}, 16'(fwd_b), 16'(efb));
    endtask

    task automatic check_model(input string tag);
        logic [1:0] sa, sb;
        sa = fsel(m.rs);
        sb = fsel(m.rt);
        check_all(tag, m.valid, m.alu, m.ctrl, m.ill, m.rd, fval(sa, m.a),
                  m.src ? m.imm : fval(sb, m.b), fval(sb, m.b), sa, sb);
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic [2:0] fn,
                          input logic src, input logic [3:0] ctrl, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [2:0] rd, input logic [15:0] rsd,
                          input logic [15:0] rtd, input logic [15:0] imm);
        id_valid = v; id_alu_op = op; id_funct = fn; id_alu_src = src; id_ctrl = ctrl;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic set_fwd(input logic mw, input logic [2:0] mrd, input logic [15:0] mres,
                           input logic ww, input logic [2:0] wrd, input logic [15:0] wres);
        mem_reg_write = mw; mem_rd = mrd; mem_result = mres;
        wb_reg_write = ww; wb_rd = wrd; wb_result = wres;
    endtask

    initial begin
        checks = 0; errors = 0; m = '0;
        optab = '{3'b010, 3'b011, 3'b000, 3'b001};
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        tick(); tick();
        #2 check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // op funct src ctrl rs rt rd rsd rtd imm v | mw mrd mres ww wrd wres | ev alu ctrl ill rd in1 in2 st fa fb
        vq.push_back(mk(2,4,0,8, 1,2,3, 5,9,0,1, 0,0,0, 0,0,0, 1,4,8,0,3, 5,9,9,0,0));
        vq.push_back(mk(2,0,0,8, 3,4,5, 7,'h44,0,1, 1,3,'h1111, 1,3,'h2222, 1,0,8,0,5, 'h1111,'h44,'h44,2,0));
        vq.push_back(mk(2,0,0,8, 3,4,5, 7,'h44,0,1, 0,3,'h1111, 1,3,'h2222, 1,0,8,0,5, 'h2222,'h44,'h44,1,0));
        vq.push_back(mk(2,1,0,8, 0,4,5, 0,'h44,0,1, 1,0,'h1111, 1,0,'h2222, 1,1,8,0,5, 0,'h44,'h44,0,0));
        vq.push_back(mk(2,6,0,8, 1,2,3, 5,9,0,1, 0,0,0, 0,0,0, 1,0,0,1,3, 5,9,9,0,0));
        vq.push_back(mk(3,0,1,8, 1,2,4, 'h0A0A,9,'hF0,1, 0,0,0, 0,0,0, 1,1,8,0,4, 'h0A0A,'hF0,9,0,0));
        vq.push_back(mk(0,0,1,'hD, 6,7,7, 'h100,'h200,'h10,1, 0,0,0, 0,0,0, 1,2,'hD,0,7, 'h100,'h10,'h200,0,0));
        vq.push_back(mk(1,0,0,0, 1,2,0, 3,3,'hFFF8,1, 0,0,0, 0,0,0, 1,3,0,0,0, 3,3,3,0,0));
        vq.push_back(mk(2,4,0,8, 3,3,3, 5,6,0,0, 1,3,'h1111, 1,3,'h2222, 0,0,0,0,0, 0,0,0,0,0));
        vq.push_back(mk(2,2,0,8, 1,5,2, 'h11,'h55,0,1, 1,5,'h3333, 1,5,'h4444, 1,2,8,0,2, 'h11,'h3333,'h3333,0,2));
        vq.push_back(mk(0,0,1,2, 1,5,0, 'h11,'h55,8,1, 0,5,'h3333, 1,5,'h4444, 1,2,2,0,0, 'h11,8,'h4444,0,1));
        vq.push_back(mk(2,5,0,'hF, 2,1,6, 1,2,0,1, 0,0,0, 0,0,0, 1,0,0,1,6, 1,2,2,0,0));
        vq.push_back(mk(2,7,0,'hF, 2,1,6, 1,2,0,1, 0,0,0, 0,0,0, 1,0,0,1,6, 1,2,2,0,0));
        vq.push_back(mk(2,3,0,8, 2,1,6, 1,2,0,1, 0,0,0, 0,0,0, 1,3,8,0,6, 1,2,2,0,0));
        foreach (vq[i]) begin
            set_id(vq[i].v, vq[i].op, vq[i].funct, vq[i].src, vq[i].ctrl, vq[i].rs, vq[i].rt,
                   vq[i].rd, vq[i].rsd, vq[i].rtd, vq[i].imm);
            set_fwd(vq[i].mw, vq[i].mrd, vq[i].mres, vq[i].ww, vq[i].wrd, vq[i].wres);
            tick();
            #2 check_all($sformatf("vec%0d", i), vq[i].ev, vq[i].ealu, vq[i].ectrl, vq[i].eill,
                         vq[i].erd, vq[i].e1, vq[i].e2, vq[i].es, vq[i].efa, vq[i].efb);
        end

        // store held through a 3-cycle stall while its WB source retires
        set_id(1, 0, 0, 1, 4'b0010, 1, 2, 0, 16'h0010, 16'h0000, 16'h0004);
        set_fwd(0, 0, 0, 1, 2, 16'hBEEF);
        tick();
        stall = 1'b1;
        set_id(1, 2, 1, 0, 4'b1000, 3, 4, 5, 16'h5555, 16'h7777, 16'h9999);
        #2 chk("stall0.input2", input2, 16'h0004);
        chk("stall0.store", ex_store_data, 16'hBEEF);
        for (int c = 1; c <= 3; c++) begin
            tick();
            wb_reg_write = 1'b0;
            #2 chk($sformatf("stall%0d.input2", c), input2, 16'h0004);
            chk($sformatf("stall%0d.store", c), ex_store_data, 16'hBEEF);
            chk($sformatf("stall%0d.ALUControl", c), 16'(ALUControl), 16'h0002);
            chk($sformatf("stall%0d.ex_ctrl", c), 16'(ex_ctrl), 16'h0002);
        end

        // flush wins over stall on the same edge
        stall = 1'b0;
        set_id(1, 2, 0, 0, 4'b1000, 1, 2, 3, 16'h1, 16'h2, 16'h0);
        tick();
        #2 chk("sf.pre_valid", 16'(ex_valid), 16'h1);
        stall = 1'b1; flush = 1'b1;
        tick();
        #2 chk("sf.ex_valid", 16'(ex_valid), 16'h0);
        chk("sf.ex_ctrl", 16'(ex_ctrl), 16'h0);
        stall = 1'b0; flush = 1'b0;

        // reset during a stall clears immediately and stays clear after release
        set_id(1, 2, 4, 0, 4'b1000, 1, 2, 3, 16'h5, 16'h9, 16'h0);
        tick();
        stall = 1'b1;
        tick();
        #2 chk("rst.pre_valid", 16'(ex_valid), 16'h1);
        reset = 1'b1; m = '0;
        #1 check_all("rst.async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        #2 reset = 1'b0; stall = 1'b0; id_valid = 1'b0;
        tick();
        #2 check_all("rst.release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            stall = $urandom_range(0, 4) == 0;
            flush = $urandom_range(0, 9) == 0;
            set_id($urandom_range(0, 4) != 0, 2'($urandom), 3'($urandom), 1'($urandom),
                   4'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            set_fwd(1'($urandom), 3'($urandom_range(0, 3)), 16'($urandom),
                    1'($urandom), 3'($urandom_range(0, 3)), 16'($urandom));
            tick();
            set_fwd(1'($urandom), 3'($urandom_range(0, 3)), 16'($urandom),
                    1'($urandom), 3'($urandom_range(0, 3)), 16'($urandom));
            #2 check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
